// File: rtl/cnt_arb_pkg.sv
// cnt_arb_pkg: shared encodings for the shared-counter arbiter.
//   cmd_t   - per-requester command codes carried on CMD
//   state_t - sequencer states of cnt_arb
package cnt_arb_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_UP   = 2'b01,
    CMD_DOWN = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_ACKS  = 2'b10
  } state_t;

endpackage

// File: rtl/cnt_arb_if.sv
// cnt_arb_if: request/grant/acknowledge bus between NREQ requesters and
// the shared counter.
//   REQ   - per-requester request level
//   CMD   - 2 bits per requester (requester i on [2i+1:2i])
//   LDVAL - WIDTH bits per requester (requester i on [WIDTH*i +: WIDTH])
//   GNT   - one-hot grant; ACK - completion pulse
//   COUNT - shared counter; WRAP - overflow/underflow pulse; BUSY - op in flight
// master: requester side, slave: arbiter side.
interface cnt_arb_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       REQ;
  logic [2*NREQ-1:0]     CMD;
  logic [WIDTH*NREQ-1:0] LDVAL;
  logic [NREQ-1:0]       GNT;
  logic                  ACK;
  logic [WIDTH-1:0]      COUNT;
  logic                  WRAP;
  logic                  BUSY;

  modport master (
    output REQ, CMD, LDVAL,
    input  GNT, ACK, COUNT, WRAP, BUSY
  );

  modport slave (
    input  REQ, CMD, LDVAL,
    output GNT, ACK, COUNT, WRAP, BUSY
  );
endinterface

// File: rtl/cnt_arb_rr_pick.sv
// cnt_arb_rr_pick: combinational round-robin picker.
//   req    - request vector
//   ptr    - index where the search starts (wraps modulo N)
//   onehot - one-hot winner, idx - its binary index, any - some request set
module cnt_arb_rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/cnt_arb.sv
// cnt_arb: round-robin arbiter sequencing NREQ requesters onto one shared
// up/down counter. Each op takes IDLE (grant) -> ISSUE (apply) -> ACKS (ack),
// so a requester sees GNT one cycle after REQ and ACK one cycle after that.
//   CLOCK - rising-edge clock
//   RESET - asynchronous active-high reset, aborts any op in flight
//   bus   - cnt_arb_if slave: REQ/CMD/LDVAL in, GNT/ACK/COUNT/WRAP/BUSY out
module cnt_arb
  import cnt_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic         CLOCK,
  input  logic         RESET,
  cnt_arb_if.slave     bus
);

  state_t           state;
  logic [NREQ-1:0]  gnt;
  logic             ack;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             busy;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win_idx;
  cmd_t             cmd_l;
  logic [WIDTH-1:0] ldval_l;

  logic [NREQ-1:0]  pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  cmd_t             cmd_sel;
  logic [WIDTH-1:0] ldval_sel;

  cnt_arb_rr_pick #(.N(NREQ)) u_pick (
    .req    (bus.REQ),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Mux the winner's command and load value out of the packed buses using
  // constant slices only.
  always_comb begin
    cmd_sel   = CMD_NOP;
    ldval_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        cmd_sel   = cmd_t'(bus.CMD[2*i +: 2]);
        ldval_sel = bus.LDVAL[WIDTH*i +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      gnt     <= '0;
      ack     <= 1'b0;
      count   <= '0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
      ptr     <= '0;
      win_idx <= '0;
      cmd_l   <= CMD_NOP;
      ldval_l <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            // Latch the command now so later CMD/LDVAL changes are ignored.
            gnt     <= pick_oh;
            win_idx <= pick_idx;
            cmd_l   <= cmd_sel;
            ldval_l <= ldval_sel;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end else begin
            gnt <= '0;
          end
        end
        S_ISSUE: begin
          case (cmd_l)
            CMD_UP: begin
              count <= count + 1'b1;
              wrap  <= &count;
            end
            CMD_DOWN: begin
              count <= count - 1'b1;
              wrap  <= ~|count;
            end
            CMD_LOAD: begin
              count <= ldval_l;
              wrap  <= 1'b0;
            end
            default: wrap <= 1'b0;
          endcase
          ack   <= 1'b1;
          state <= S_ACKS;
        end
        S_ACKS: begin
          // Advancing past the winner keeps a persistent requester from
          // being served back-to-back while others wait.
          ptr   <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
          gnt   <= '0;
          ack   <= 1'b0;
          wrap  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.GNT   = gnt;
  assign bus.ACK   = ack;
  assign bus.COUNT = count;
  assign bus.WRAP  = wrap;
  assign bus.BUSY  = busy;

endmodule

// File: tb/tb_cnt_arb.sv
// tb_cnt_arb: directed bench for cnt_arb. A table of single-op vectors with
// hand-computed grants/counts, plus sequences for persistent requesters and
// reset in the middle of an op.
module tb_cnt_arb;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 CLOCK = ~CLOCK;

  cnt_arb_if #(.NREQ(4), .WIDTH(4)) bus ();

  cnt_arb #(.NREQ(4), .WIDTH(4)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  cmd;
    logic [15:0] ldval;
    logic        chg;    // rewrite CMD/LDVAL to DOWN/A while granted
    logic [3:0]  gnt;
    logic [3:0]  cnt;
    logic        wrap;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    bus.REQ = '0;
    repeat (2) @(negedge CLOCK);
    chk("rst_count", 32'(bus.COUNT), 0);
    chk("rst_gnt",   32'(bus.GNT),   0);
    chk("rst_ack",   32'(bus.ACK),   0);
    chk("rst_wrap",  32'(bus.WRAP),  0);
    chk("rst_busy",  32'(bus.BUSY),  0);
    RESET = 1'b0;
  endtask

  // One complete op; REQ is dropped right after the grant is seen.
  task automatic run_op(input string nm, input logic [3:0] req, input logic [7:0] cmd,
                        input logic [15:0] ld, input logic chg, input logic [3:0] egnt,
                        input logic [3:0] ecnt, input logic ewrap);
    @(negedge CLOCK);
    chk({nm, "_idle_gnt"}, 32'(bus.GNT), 0);
    chk({nm, "_idle_busy"}, 32'(bus.BUSY), 0);
    bus.REQ = req;
    bus.CMD = cmd;
    bus.LDVAL = ld;
    @(negedge CLOCK);
    chk({nm, "_gnt"}, 32'(bus.GNT), 32'(egnt));
    chk({nm, "_busy"}, 32'(bus.BUSY), 1);
    chk({nm, "_ack_early"}, 32'(bus.ACK), 0);
    bus.REQ = '0;
    if (chg) begin
      bus.CMD = 8'hAA;
      bus.LDVAL = 16'hAAAA;
    end
    @(negedge CLOCK);
    chk({nm, "_ack"}, 32'(bus.ACK), 1);
    chk({nm, "_count"}, 32'(bus.COUNT), 32'(ecnt));
    chk({nm, "_wrap"}, 32'(bus.WRAP), 32'(ewrap));
    chk({nm, "_gnt_hold"}, 32'(bus.GNT), 32'(egnt));
    @(negedge CLOCK);
    chk({nm, "_ack_clr"}, 32'(bus.ACK), 0);
    chk({nm, "_gnt_clr"}, 32'(bus.GNT), 0);
    chk({nm, "_busy_clr"}, 32'(bus.BUSY), 0);
    chk({nm, "_wrap_clr"}, 32'(bus.WRAP), 0);
  endtask

  initial begin
    bus.REQ = '0;
    bus.CMD = '0;
    bus.LDVAL = '0;

    //           req      cmd    ldval     chg   gnt      cnt   wrap
    vt[0] = '{4'b0001, 8'h01, 16'h0000, 1'b0, 4'b0001, 4'h1, 1'b0}; // req0 UP
    vt[1] = '{4'b0100, 8'h30, 16'h0F00, 1'b0, 4'b0100, 4'hF, 1'b0}; // req2 LOAD F
    vt[2] = '{4'b0100, 8'h10, 16'h0000, 1'b0, 4'b0100, 4'h0, 1'b1}; // UP from F
    vt[3] = '{4'b0100, 8'h20, 16'h0000, 1'b0, 4'b0100, 4'hF, 1'b1}; // DOWN from 0
    vt[4] = '{4'b0010, 8'h0C, 16'h0050, 1'b1, 4'b0010, 4'h5, 1'b0}; // LOAD 5, cmd changes
    vt[5] = '{4'b1000, 8'h00, 16'h0000, 1'b0, 4'b1000, 4'h5, 1'b0}; // req3 NOP
    vt[6] = '{4'b1010, 8'h44, 16'h0000, 1'b0, 4'b0010, 4'h6, 1'b0}; // ptr 0: req1 wins
    vt[7] = '{4'b0001, 8'h02, 16'h0000, 1'b0, 4'b0001, 4'h5, 1'b0}; // req0 DOWN
    vt[8] = '{4'b1001, 8'h41, 16'h0000, 1'b0, 4'b1000, 4'h6, 1'b0}; // ptr 1: req3 wins
    vt[9] = '{4'b1001, 8'h41, 16'h0000, 1'b0, 4'b0001, 4'h7, 1'b0}; // ptr 0: req0 wins

    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].req, vt[i].cmd, vt[i].ldval, vt[i].chg,
             vt[i].gnt, vt[i].cnt, vt[i].wrap);
    end

    // All four requesters hold REQ with UP: strict rotation, one op per 3 cycles.
    do_reset();
    bus.REQ = 4'b1111;
    bus.CMD = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK);
      chk($sformatf("rr%0d_gnt", k), 32'(bus.GNT), 32'(1 << (k % 4)));
      chk($sformatf("rr%0d_ack_lo", k), 32'(bus.ACK), 0);
      @(negedge CLOCK);
      chk($sformatf("rr%0d_ack", k), 32'(bus.ACK), 1);
      chk($sformatf("rr%0d_count", k), 32'(bus.COUNT), 32'(k + 1));
      @(negedge CLOCK);
      chk($sformatf("rr%0d_ack_clr", k), 32'(bus.ACK), 0);
      chk($sformatf("rr%0d_gnt_clr", k), 32'(bus.GNT), 0);
    end
    bus.REQ = '0;

    // Reset during ISSUE with COUNT=7 and PTR=2 pending an UP from req2.
    run_op("ld7", 4'b0010, 8'h0C, 16'h0070, 1'b0, 4'b0010, 4'h7, 1'b0);
    @(negedge CLOCK);
    bus.REQ = 4'b0100;
    bus.CMD = 8'h10;
    @(negedge CLOCK);
    chk("mid_gnt", 32'(bus.GNT), 32'(4'b0100));
    RESET = 1'b1;
    #1;
    chk("mid_count", 32'(bus.COUNT), 0);
    chk("mid_gnt0", 32'(bus.GNT), 0);
    chk("mid_busy", 32'(bus.BUSY), 0);
    chk("mid_ack", 32'(bus.ACK), 0);
    bus.REQ = '0;
    @(negedge CLOCK);
    chk("mid_ack_after", 32'(bus.ACK), 0);
    chk("mid_count_after", 32'(bus.COUNT), 0);
    RESET = 1'b0;
    run_op("post_rst", 4'b0101, 8'h11, 16'h0000, 1'b0, 4'b0001, 4'h1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
